// File: rtl/radio_pkg.sv
// radio_pkg: shared types and helpers for the hourly radio time-signal player.
//   state_e            sequencer states
//   tone_e             tone select driven into radio_tone_gen
//   bcd_hr_to_strikes  packed-BCD hour -> strike count (0 for an invalid hour)
package radio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PIP_ON,
        PIP_OFF,
        LONG,
        STRIKE_ON,
        STRIKE_OFF
    } state_e;

    typedef enum logic [1:0] {
        TONE_OFF,
        TONE_LO,
        TONE_HI
    } tone_e;

    // 12-hour strike count: hour mod 12 with 0 mapped to 12; invalid BCD or >23 gives 0.
    function automatic logic [3:0] bcd_hr_to_strikes(input logic [7:0] hour);
        logic [3:0] tens;
        logic [3:0] ones;
        logic [4:0] bin;
        tens = hour[7:4];
        ones = hour[3:0];
        if (ones > 4'd9 || tens > 4'd2 || (tens == 4'd2 && ones > 4'd3)) begin
            return 4'd0;
        end
        bin = 5'(tens) * 5'd10 + 5'(ones);
        if (bin >= 5'd12) begin
            bin = bin - 5'd12;
        end
        if (bin == 5'd0) begin
            return 4'd12;
        end
        return bin[3:0];
    endfunction

endpackage

// File: rtl/radio_tone_gen.sv
// radio_tone_gen: registered square-wave generator for the chime speaker.
//   CP        system clock
//   CR        synchronous active-high clear
//   tone_sel  requested tone (off / 500 Hz low / 1 kHz high at a 2 kHz clock)
//   wave      registered square wave; restarts at 1 whenever tone_sel changes
module radio_tone_gen
    import radio_pkg::*;
(
    input  logic  CP,
    input  logic  CR,
    input  tone_e tone_sel,
    output logic  wave
);

    tone_e tone_q;
    logic  phase_q;
    logic  wave_q;

    always_ff @(posedge CP) begin
        if (CR) begin
            tone_q  <= TONE_OFF;
            phase_q <= 1'b0;
            wave_q  <= 1'b0;
        end else if (tone_sel != tone_q) begin
            // Every on-phase starts high on its first cycle.
            tone_q  <= tone_sel;
            phase_q <= 1'b0;
            wave_q  <= (tone_sel != TONE_OFF);
        end else begin
            unique case (tone_q)
                TONE_HI: wave_q <= ~wave_q;
                TONE_LO: begin
                    // Toggle on every second cycle.
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        wave_q <= ~wave_q;
                    end
                end
                default: wave_q <= 1'b0;
            endcase
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/radio_chime_player.sv
// radio_chime_player: plays the hourly pip sequence on a one-bit speaker line.
//   CP           system clock (2 kHz)
//   CR           synchronous active-high clear
//   ALARM_Radio  hourly alarm level; a rising edge seen while idle starts a sequence
//   Hour         packed-BCD hour, captured at start (strike build only)
//   Mute         forces Speaker low without affecting sequencing
//   Speaker      tone output
//   Busy         high while a sequence is running
//   Done         high on the final cycle of a sequence
// Optional feature: define RADIO_STRIKE_EN to strike the hour count after the long pip.
module radio_chime_player
    import radio_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 2000,
    parameter int unsigned PIPS          = 5,
    parameter int unsigned PIP_TICKS     = 200,
    parameter int unsigned LONG_TICKS    = 1000,
    parameter int unsigned STRIKE_TICKS  = 600,
    parameter int unsigned STRIKE_GAP    = 1400
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       ALARM_Radio,
    input  logic [7:0] Hour,
    input  logic       Mute,
    output logic       Speaker,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned MaxA = (TICKS_PER_SEC > LONG_TICKS) ? TICKS_PER_SEC : LONG_TICKS;
    localparam int unsigned MaxPhase =
        (MaxA > STRIKE_TICKS + STRIKE_GAP) ? MaxA : STRIKE_TICKS + STRIKE_GAP;
    localparam int unsigned CW = $clog2(MaxPhase + 1);

    localparam logic [CW-1:0] PipOnLast  = CW'(PIP_TICKS - 1);
    localparam logic [CW-1:0] PipOffLast = CW'(TICKS_PER_SEC - PIP_TICKS - 1);
    localparam logic [CW-1:0] LongLast   = CW'(LONG_TICKS - 1);
    localparam logic [3:0]    PipFinal   = 4'(PIPS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [3:0]    pip_q;
    logic          alarm_q;
    logic          busy_q;
    logic          start;
    logic          seq_last;
    tone_e         tone_sel;
    logic          wave;

    assign start = ALARM_Radio & ~alarm_q;

`ifdef RADIO_STRIKE_EN
    localparam logic [CW-1:0] StrikeOnLast  = CW'(STRIKE_TICKS - 1);
    localparam logic [CW-1:0] StrikeOffLast = CW'(STRIKE_GAP - 1);

    logic [7:0] hour_q;
    logic [3:0] strike_n;
    logic [3:0] strike_q;

    assign strike_n = bcd_hr_to_strikes(hour_q);
    assign seq_last = (state_q == LONG && cnt_q == LongLast && strike_n == 4'd0) ||
                      (state_q == STRIKE_OFF && cnt_q == StrikeOffLast && strike_q == strike_n);
`else
    logic unused_hour;
    assign unused_hour = ^Hour;
    assign seq_last    = (state_q == LONG && cnt_q == LongLast);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (PIPS == 1) ? LONG : PIP_ON;
            PIP_ON:  if (cnt_q == PipOnLast) state_d = PIP_OFF;
            PIP_OFF: if (cnt_q == PipOffLast) state_d = (pip_q == PipFinal) ? LONG : PIP_ON;
`ifdef RADIO_STRIKE_EN
            LONG:       if (cnt_q == LongLast) state_d = seq_last ? IDLE : STRIKE_ON;
            STRIKE_ON:  if (cnt_q == StrikeOnLast) state_d = STRIKE_OFF;
            STRIKE_OFF: if (cnt_q == StrikeOffLast) state_d = seq_last ? IDLE : STRIKE_ON;
`else
            LONG:       if (cnt_q == LongLast) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Tone follows the next state so Speaker is high on the first cycle of each on-phase.
    always_comb begin
        tone_sel = TONE_OFF;
        if (!CR) begin
            unique case (state_d)
                PIP_ON, STRIKE_ON: tone_sel = TONE_LO;
                LONG:              tone_sel = TONE_HI;
                default:           tone_sel = TONE_OFF;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pip_q   <= '0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RADIO_STRIKE_EN
            hour_q   <= '0;
            strike_q <= '0;
`endif
        end else begin
            alarm_q <= ALARM_Radio;
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            cnt_q   <= (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + 1'b1;
            if (state_d == IDLE) begin
                pip_q <= '0;
            end else if (state_d == PIP_ON && state_q != PIP_ON) begin
                pip_q <= pip_q + 4'd1;
            end
`ifdef RADIO_STRIKE_EN
            if (state_q == IDLE && start) begin
                hour_q <= Hour;
            end
            if (state_d == IDLE) begin
                strike_q <= '0;
            end else if (state_d == STRIKE_ON && state_q != STRIKE_ON) begin
                strike_q <= strike_q + 4'd1;
            end
`endif
        end
    end

    radio_tone_gen u_tone (
        .CP       (CP),
        .CR       (CR),
        .tone_sel (tone_sel),
        .wave     (wave)
    );

    assign Speaker = wave & ~Mute;
    assign Busy    = busy_q;
    assign Done    = seq_last;

endmodule

// File: tb/tb_radio_chime_player.sv
// tb_radio_chime_player: directed self-checking bench for radio_chime_player.
// Cycle t is the t-th clock edge after reset release; inputs change 1 time unit after edge t
// and outputs are sampled 2 time units after it.
module tb_radio_chime_player;

    logic       CP = 1'b0;
    logic       CR;
    logic       ALARM_Radio;
    logic [7:0] Hour;
    logic       Mute;
    logic       Speaker;
    logic       Busy;
    logic       Done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CP = ~CP;

    radio_chime_player dut (
        .CP          (CP),
        .CR          (CR),
        .ALARM_Radio (ALARM_Radio),
        .Hour        (Hour),
        .Mute        (Mute),
        .Speaker     (Speaker),
        .Busy        (Busy),
        .Done        (Done)
    );

    // Expected outputs k cycles after sequence start (defaults: 4 short pips, long pip, strikes).
    function automatic void model(input int k, input int n_strk,
                                  output logic spk, output logic busy, output logic done);
        int len;
        int p;
        len  = 9000 + 2000 * n_strk;
        spk  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        if (k >= 0 && k < len) begin
            busy = 1'b1;
            done = (k == len - 1);
            if (k < 8000) begin
                p   = k % 2000;
                spk = (p < 200) && ((p / 2) % 2 == 0);
            end else if (k < 9000) begin
                spk = ((k - 8000) % 2 == 0);
            end else begin
                p   = (k - 9000) % 2000;
                spk = (p < 600) && ((p / 2) % 2 == 0);
            end
        end
    endfunction

    task automatic do_reset();
        CR          = 1'b1;
        ALARM_Radio = 1'b0;
        Mute        = 1'b0;
        repeat (3) @(posedge CP);
        #1;
        CR = 1'b0;
    endtask

    task automatic test_reset();
        CR          = 1'b1;
        ALARM_Radio = 1'b1;
        Mute        = 1'b0;
        Hour        = 8'h1A;
        repeat (4) @(posedge CP);
        #2;
        n_cmp++;
        if (Speaker !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_speaker: got %b want 0", Speaker);
        end
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", Busy);
        end
        n_cmp++;
        if (Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done: got %b want 0", Done);
        end
        ALARM_Radio = 1'b0;
    endtask

    // mode 0 pulse, 1 held level with extra edge, 2 mute window, 3 clear mid-pip then
    // fresh start, 4 clear with level held high (restarts after release).
    task automatic run_window(input string name, input int mode, input logic [7:0] hour,
                              input int n_strk);
        int   len, s_fin, n_cyc, s;
        int   bad_spk, bad_busy, bad_done, first_spk, first_busy, first_done;
        logic e_spk, e_busy, e_done, zero, mute_now;
        len   = 9000 + 2000 * n_strk;
        s_fin = (mode == 3) ? 4201 : (mode == 4) ? 102 : 11;
        n_cyc = s_fin + len + ((mode == 1) ? 300 : 20);
        bad_spk  = 0; bad_busy  = 0; bad_done  = 0;
        first_spk = -1; first_busy = -1; first_done = -1;
        do_reset();
        Hour = hour;
        for (int t = 1; t <= n_cyc; t++) begin
            @(posedge CP);
            #1;
            unique case (mode)
                1:       ALARM_Radio = (t >= 10) && !(t >= 2990 && t < 3000);
                3:       ALARM_Radio = (t >= 10 && t < 20) || (t >= 4200 && t < 4210);
                4:       ALARM_Radio = (t >= 10);
                default: ALARM_Radio = (t >= 10 && t < 20);
            endcase
            CR       = (mode == 3 && t == 4100) || (mode == 4 && t == 100);
            mute_now = (mode == 2) && t >= 500 && t <= 4500;
            Mute     = mute_now;
            #1;
            zero = (mode == 3 && t >= 4101 && t < 4201) || (mode == 4 && t == 101);
            s    = (mode == 3 && t >= 4201) ? 4201 : (mode == 4 && t >= 102) ? 102 : 11;
            if (zero) begin
                e_spk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                model(t - s, n_strk, e_spk, e_busy, e_done);
            end
            if (mute_now) e_spk = 1'b0;
            if (Speaker !== e_spk) begin
                if (bad_spk == 0) first_spk = t;
                bad_spk++;
            end
            if (Busy !== e_busy) begin
                if (bad_busy == 0) first_busy = t;
                bad_busy++;
            end
            if (Done !== e_done) begin
                if (bad_done == 0) first_done = t;
                bad_done++;
            end
            if (t == s_fin) begin
                n_cmp++;
                if (Busy !== 1'b1 || Speaker !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s_start: busy=%b speaker=%b at %0d want 1/1",
                             name, Busy, Speaker, t);
                end
            end
            if (t == s_fin + len - 1) begin
                n_cmp++;
                if (Done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s_done: done=%b at %0d want 1", name, Done, t);
                end
            end
            if (t == s_fin + len) begin
                n_cmp++;
                if (Busy !== 1'b0 || Done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s_end: busy=%b done=%b at %0d want 0/0",
                             name, Busy, Done, t);
                end
            end
        end
        n_cmp++;
        if (bad_spk !== 0) begin
            n_bad++;
            $display("FAIL %s_speaker: %0d bad cycles (first %0d) want 0", name, bad_spk,
                     first_spk);
        end
        n_cmp++;
        if (bad_busy !== 0) begin
            n_bad++;
            $display("FAIL %s_busy: %0d bad cycles (first %0d) want 0", name, bad_busy,
                     first_busy);
        end
        n_cmp++;
        if (bad_done !== 0) begin
            n_bad++;
            $display("FAIL %s_done_wave: %0d bad cycles (first %0d) want 0", name, bad_done,
                     first_done);
        end
        ALARM_Radio = 1'b0;
    endtask

    task automatic test_basic();
        run_window("basic", 0, 8'h1A, 0);
    endtask

    task automatic test_hold_level();
        run_window("hold", 1, 8'h1A, 0);
    endtask

    task automatic test_mute();
        run_window("mute", 2, 8'h1A, 0);
    endtask

    task automatic test_clear_mid();
        run_window("clear", 3, 8'h1A, 0);
    endtask

    task automatic test_clear_held();
        run_window("clear_held", 4, 8'h1A, 0);
    endtask

`ifdef RADIO_STRIKE_EN
    task automatic test_strikes();
        run_window("strike_h15", 0, 8'h15, 3);
        run_window("strike_h00", 0, 8'h00, 12);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold_level();
        test_mute();
        test_clear_mid();
        test_clear_held();
`ifdef RADIO_STRIKE_EN
        test_strikes();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
